// File: rtl/stft_frame_tx.sv
// STFT frame transmitter: latches one N-word frame in a single cycle
// and streams it out word by word over a valid/ready handshake.
module stft_frame_tx #(
  parameter int WL = 16,
  parameter int N  = 8,
  parameter int CW = 3
) (
  input  logic            iCLK,
  input  logic            iRSTn,
  input  logic            iCLR,
  input  logic            iLOAD,
  input  logic [N*WL-1:0] iFRAME,
  input  logic            iREADY,
  output logic            oVALID,
  output logic [WL-1:0]   oDATA,
  output logic [CW-1:0]   oIDX,
  output logic            oLAST,
  output logic            oBUSY,
  output logic            oDONE
);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N*WL-1:0]   bank_q, bank_d;
  logic              done_q, done_d;

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bank_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    done_d  = 1'b0;
    if (iCLR) begin
      state_d = IDLE;
      cnt_d   = '0;
      bank_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (iLOAD) begin
            bank_d  = iFRAME;
            cnt_d   = '0;
            state_d = SEND;
          end
        end
        SEND: begin
          if (iREADY) begin
            if (cnt_q == LAST_IDX) begin
              state_d = IDLE;
              cnt_d   = '0;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Outputs depend only on registered state; zero-filled while idle.
  always_comb begin
    oVALID = 1'b0;
    oBUSY  = 1'b0;
    oDATA  = '0;
    oIDX   = '0;
    oLAST  = 1'b0;
    if (state_q == SEND) begin
      oVALID = 1'b1;
      oBUSY  = 1'b1;
      oDATA  = bank_q[cnt_q*WL +: WL];
      oIDX   = cnt_q;
      oLAST  = (cnt_q == LAST_IDX);
    end
  end

  assign oDONE = done_q;

endmodule

// File: tb/tb_stft_frame_tx.sv
// Scoreboard bench for stft_frame_tx: expected words are queued on load
// and matched against every accepted handshake.
module tb_stft_frame_tx;

  localparam int WL = 16;
  localparam int N  = 8;
  localparam int CW = 3;

  typedef struct {
    logic [WL-1:0] d;
    logic [CW-1:0] i;
    logic          l;
  } exp_t;

  logic            iCLK;
  logic            iRSTn;
  logic            iCLR;
  logic            iLOAD;
  logic [N*WL-1:0] iFRAME;
  logic            iREADY;
  logic            oVALID;
  logic [WL-1:0]   oDATA;
  logic [CW-1:0]   oIDX;
  logic            oLAST;
  logic            oBUSY;
  logic            oDONE;

  int checks;
  int errors;
  int xfers;

  exp_t sb[$];
  exp_t e_m;

  logic          stall_m;
  logic [WL-1:0] sd_m;
  logic [CW-1:0] si_m;
  logic          sl_m;

  stft_frame_tx #(.WL(WL), .N(N), .CW(CW)) dut (
    .iCLK  (iCLK),
    .iRSTn (iRSTn),
    .iCLR  (iCLR),
    .iLOAD (iLOAD),
    .iFRAME(iFRAME),
    .iREADY(iREADY),
    .oVALID(oVALID),
    .oDATA (oDATA),
    .oIDX  (oIDX),
    .oLAST (oLAST),
    .oBUSY (oBUSY),
    .oDONE (oDONE)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  initial stall_m = 1'b0;

  // Inputs change at posedge+1, so they are stable here until the next edge.
  always @(negedge iCLK) begin
    if (iRSTn && !iCLR && oVALID && iREADY) begin
      xfers++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL xfer_unexpected got d=%h i=%0d", oDATA, oIDX);
      end else begin
        e_m = sb.pop_front();
        if (oDATA !== e_m.d || oIDX !== e_m.i || oLAST !== e_m.l) begin
          errors++;
          $display("FAIL xfer got d=%h i=%0d l=%b exp d=%h i=%0d l=%b",
                   oDATA, oIDX, oLAST, e_m.d, e_m.i, e_m.l);
        end
      end
    end
    if (stall_m && oVALID) begin
      checks++;
      if (oDATA !== sd_m || oIDX !== si_m || oLAST !== sl_m) begin
        errors++;
        $display("FAIL stall_hold got d=%h i=%0d exp d=%h i=%0d",
                 oDATA, oIDX, sd_m, si_m);
      end
    end
    stall_m = iRSTn && !iCLR && oVALID && !iREADY;
    sd_m = oDATA;
    si_m = oIDX;
    sl_m = oLAST;
  end

  task automatic cyc();
    @(posedge iCLK);
    #1;
  endtask

  task automatic set_frame(input logic [WL-1:0] base, input bit incr);
    for (int k = 0; k < N; k++)
      iFRAME[k*WL +: WL] = incr ? base + WL'(k) : base;
  endtask

  task automatic load_frame(input logic [WL-1:0] base);
    exp_t e;
    set_frame(base, 1'b1);
    for (int k = 0; k < N; k++) begin
      e.d = base + WL'(k);
      e.i = CW'(k);
      e.l = (k == N - 1);
      sb.push_back(e);
    end
    iLOAD = 1'b1;
    cyc();
    iLOAD = 1'b0;
  endtask

  task automatic wait_idx(input logic [CW-1:0] t, input int budget);
    int n = 0;
    while (!(oVALID && oIDX == t) && n < budget) begin
      cyc();
      n++;
    end
    checks++;
    if (!(oVALID && oIDX == t)) begin
      errors++;
      $display("FAIL wait_idx timeout got i=%0d exp i=%0d", oIDX, t);
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!oDONE && n < budget) begin
      cyc();
      n++;
    end
    checks++;
    if (oDONE !== 1'b1) begin
      errors++;
      $display("FAIL wait_done timeout got %b exp 1", oDONE);
    end
  endtask

  task automatic test_reset();
    iRSTn = 1'b0;
    #1;
    checks++;
    if ({oVALID, oDATA, oIDX, oLAST, oBUSY, oDONE} !== '0) begin
      errors++;
      $display("FAIL reset_init got v=%b d=%h i=%0d exp all 0",
               oVALID, oDATA, oIDX);
    end
    #12 iRSTn = 1'b1;
    cyc();
    checks++;
    if (oVALID !== 1'b0 || oBUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got v=%b b=%b exp 0 0", oVALID, oBUSY);
    end
    iREADY = 1'b1;
    load_frame(16'h1000);
    wait_idx(3'd3, 20);
    iRSTn = 1'b0;
    #1;
    checks++;
    if ({oVALID, oDATA, oIDX, oLAST, oBUSY, oDONE} !== '0) begin
      errors++;
      $display("FAIL reset_async got v=%b d=%h i=%0d b=%b exp all 0",
               oVALID, oDATA, oIDX, oBUSY);
    end
    sb.delete();
    cyc();
    iRSTn = 1'b1;
    cyc();
    checks++;
    if (oVALID !== 1'b0 || oDONE !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got v=%b done=%b exp 0 0", oVALID, oDONE);
    end
  endtask

  task automatic test_basic();
    int x0 = xfers;
    iREADY = 1'b1;
    load_frame(16'h1000);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (oVALID !== 1'b1) begin
        errors++;
        $display("FAIL basic_valid cycle %0d got %b exp 1", i, oVALID);
      end
      cyc();
    end
    checks++;
    if (oDONE !== 1'b1 || oVALID !== 1'b0) begin
      errors++;
      $display("FAIL basic_done got done=%b v=%b exp 1 0", oDONE, oVALID);
    end
    cyc();
    checks++;
    if (oDONE !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse got %b exp 0", oDONE);
    end
    checks++;
    if (xfers - x0 != N || sb.size() != 0) begin
      errors++;
      $display("FAIL basic_count got %0d left %0d exp %0d left 0",
               xfers - x0, sb.size(), N);
    end
  endtask

  task automatic test_backpressure();
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int x0 = xfers;
    int n = 0;
    load_frame(16'h1000);
    while (!oDONE && n < 60) begin
      iREADY = pat[n % 4];
      cyc();
      n++;
    end
    iREADY = 1'b1;
    checks++;
    if (oDONE !== 1'b1) begin
      errors++;
      $display("FAIL bp_timeout got %b exp 1", oDONE);
    end
    checks++;
    if (xfers - x0 != N || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_count got %0d left %0d exp %0d left 0",
               xfers - x0, sb.size(), N);
    end
    cyc();
  endtask

  task automatic test_load_during_send();
    int n = 0;
    iREADY = 1'b1;
    load_frame(16'h1000);
    while (!oDONE && n < 30) begin
      iLOAD = oVALID && (oIDX == 3'd2 || oIDX == 3'd7);
      if (iLOAD) set_frame(16'hAAAA, 1'b0);
      cyc();
      n++;
    end
    iLOAD = 1'b0;
    checks++;
    if (oDONE !== 1'b1 || oVALID !== 1'b0) begin
      errors++;
      $display("FAIL lds_done got done=%b v=%b exp 1 0", oDONE, oVALID);
    end
    cyc();
    checks++;
    if (oVALID !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL lds_ignored got v=%b left %0d exp 0 0",
               oVALID, sb.size());
    end
  endtask

  task automatic test_clear();
    iREADY = 1'b1;
    load_frame(16'h1000);
    wait_idx(3'd5, 20);
    iCLR = 1'b1;
    cyc();
    iCLR = 1'b0;
    checks++;
    if (oVALID !== 1'b0 || oBUSY !== 1'b0 || oDONE !== 1'b0) begin
      errors++;
      $display("FAIL clr got v=%b b=%b done=%b exp 0 0 0",
               oVALID, oBUSY, oDONE);
    end
    checks++;
    if (sb.size() != 3) begin
      errors++;
      $display("FAIL clr_left got %0d exp 3", sb.size());
    end
    sb.delete();
    cyc();
    checks++;
    if (oDONE !== 1'b0) begin
      errors++;
      $display("FAIL clr_nodone got %b exp 0", oDONE);
    end
    load_frame(16'h3000);
    checks++;
    if (oVALID !== 1'b1 || oIDX !== 3'd0 || oDATA !== 16'h3000) begin
      errors++;
      $display("FAIL clr_restart got v=%b i=%0d d=%h exp 1 0 3000",
               oVALID, oIDX, oDATA);
    end
    wait_done(20);
    cyc();
  endtask

  task automatic test_back_to_back();
    iREADY = 1'b1;
    load_frame(16'h1000);
    wait_done(20);
    checks++;
    if (oVALID !== 1'b0) begin
      errors++;
      $display("FAIL b2b_bubble got v=%b exp 0", oVALID);
    end
    load_frame(16'h2000);
    checks++;
    if (oVALID !== 1'b1 || oIDX !== 3'd0 || oDATA !== 16'h2000) begin
      errors++;
      $display("FAIL b2b_start got v=%b i=%0d d=%h exp 1 0 2000",
               oVALID, oIDX, oDATA);
    end
    wait_done(20);
    cyc();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_left got %0d exp 0", sb.size());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    xfers  = 0;
    iRSTn  = 1'b0;
    iCLR   = 1'b0;
    iLOAD  = 1'b0;
    iREADY = 1'b0;
    iFRAME = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_load_during_send();
    test_clear();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stft_frame_tx.md
Name: stft_frame_tx

Overview:
Frame transmitter for the STFT datapath: captures one parallel frame of N samples in a single cycle and streams it out word by word over a valid/ready handshake.
It is the unloading counterpart of the team's enable/clear data registers, which write and hold parallel words.
It sits between the frame/window register bank and the downstream FFT input stage, which may apply back-pressure.

Parameters:
WL, 16, sample word length in bits
N, 8, words per frame (N >= 2)
CW, 3, index/counter width, CW = ceil(log2(N))

Ports:
iCLK  input  1  system clock, all state on rising edge
iRSTn  input  1  asynchronous active-low reset
iCLR  input  1  synchronous clear, highest priority after reset
iLOAD  input  1  frame load request, accepted only in IDLE
iFRAME  input  N*WL  parallel frame; word k = iFRAME[k*WL +: WL], word 0 sent first
iREADY  input  1  downstream ready
oVALID  output  1  oDATA/oIDX/oLAST valid
oDATA  output  WL  current word
oIDX  output  CW  index of current word, 0..N-1
oLAST  output  1  high with oVALID when oIDX == N-1
oBUSY  output  1  high in SEND state
oDONE  output  1  one-cycle pulse after final transfer

Behaviour:
- Clock/reset: one clock (iCLK); reset asynchronous, active-low (iRSTn). Reset forces state IDLE and clears the internal frame bank and the word counter. All outputs go to 0: oVALID, oDATA, oIDX, oLAST, oBUSY, oDONE.
- iCLR (synchronous): same effect as reset on the next edge. It overrides iLOAD and any handshake in that cycle, including a mid-frame transfer; no oDONE is produced.
- FSM: two states, IDLE and SEND.
- IDLE:
  - oVALID=0, oBUSY=0, oDATA=0, oIDX=0, oLAST=0.
  - iLOAD=1 captures iFRAME into the bank, sets counter=0 and goes to SEND.
  - Latency: the first word appears on oVALID/oDATA on the cycle after the load edge.
- SEND:
  - oVALID=1, oBUSY=1, oDATA=bank word[counter], oIDX=counter, oLAST=(counter==N-1).
  - Transfer occurs on an edge where oVALID & iREADY.
  - Transfer with counter<N-1: counter+1.
  - Transfer with counter==N-1: go to IDLE, counter=0, oDONE=1 for exactly the next cycle.
  - iREADY=0 stalls: oDATA, oIDX and oLAST hold stable; no word may be dropped or repeated.
- iLOAD while in SEND, including the final-transfer cycle: ignored; the bank is not overwritten.
- iLOAD in IDLE during the oDONE cycle: accepted normally, so back-to-back frames have one idle bubble. Maximum throughput is N words per N+1 cycles.
- oDATA/oIDX are driven from registered state, with no combinational path from iREADY to outputs.
- Counter never wraps past N-1; the value N is unreachable.
- Outputs are zero-filled in IDLE, not holding the last word.

Test Plan:
- Reset: assert iRSTn=0 mid-SEND at word 3 -> all outputs 0 immediately (asynchronously); after release the block is in IDLE with oVALID=0.
- Basic frame: iFRAME words k = 16'h1000+k, iLOAD pulse, iREADY=1 held -> oVALID high for 8 consecutive cycles starting 1 cycle after load. oDATA 1000..1007, oIDX 0..7, oLAST only on 1007, oDONE pulse on the following cycle.
- Back-pressure: same frame, iREADY toggling 1,0,0,1,... -> every word appears exactly once and in order; oDATA is stable through stall cycles; total transfers = 8.
- Load during SEND: iLOAD with a new frame (words 16'hAAAA) at word 2 -> the remaining words continue as 1002..1007 and no AAAA word is ever output.
- Clear mid-frame: iCLR=1 at word 5 with iREADY=1 -> next cycle oVALID=0, oBUSY=0, no oDONE; a subsequent load restarts at oIDX=0.
- Back-to-back: iLOAD asserted in the oDONE cycle with words 16'h2000+k -> the new frame starts with exactly 1 idle cycle between 1007 and 2000.
